// File: rtl/seven_seg_4dig_scan.sv
`default_nettype none
// ============================================================================
//  Module  : seven_seg_4dig_scan
//  Brief   : Four-digit common-anode seven-segment scanner with frame-synced
//            shadow registers, per-slot anti-ghost guard and optional
//            leading-zero blanking.
//  Rev     : 1.0  initial release
// ============================================================================
module seven_seg_4dig_scan #(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 1000,
   parameter bit LZ_BLANK    = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an
);

   localparam int               CNT_W      = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [6:0]       C_SEG_OFF  = 7'b1111111;
   localparam logic [3:0]       C_AN_OFF   = 4'b1111;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
      endcase
      return s;
   endfunction

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [15:0]      sh_value_q, sh_value_d;
   logic [3:0]       sh_dp_q, sh_dp_d;
   logic [3:0]       sh_blank_q, sh_blank_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       an_q, an_d;

   logic             slot_last;
   logic             in_guard;
   logic [3:0]       cur_nib;
   logic [3:0]       lz_dark;
   logic             digit_dark;

   generate
      if (GUARD > 0) begin : g_guard
         localparam logic [CNT_W-1:0] C_GUARD = CNT_W'(GUARD);
         assign in_guard = (cnt_q < C_GUARD);
      end else begin : g_no_guard
         assign in_guard = 1'b0;
      end
   endgenerate

   // A digit is a leading zero when it and every digit to its left are zero.
   always_comb begin
      lz_dark = 4'b0000;
      if (LZ_BLANK) begin
         lz_dark[3] = (sh_value_q[15:12] == 4'h0);
         lz_dark[2] = lz_dark[3] && (sh_value_q[11:8] == 4'h0);
         lz_dark[1] = lz_dark[2] && (sh_value_q[7:4] == 4'h0);
      end
   end

   always_comb begin
      slot_last  = (cnt_q == C_CNT_LAST);
      cnt_d      = slot_last ? '0 : cnt_q + CNT_W'(1);
      idx_d      = slot_last ? idx_q + 2'd1 : idx_q;
      sh_value_d = sh_value_q;
      sh_dp_d    = sh_dp_q;
      sh_blank_d = sh_blank_q;
      if (slot_last && (idx_q == 2'd3)) begin
         sh_value_d = value;
         sh_dp_d    = dp_in;
         sh_blank_d = blank;
      end
   end

   always_comb begin
      case (idx_q)
         2'd0:    cur_nib = sh_value_q[3:0];
         2'd1:    cur_nib = sh_value_q[7:4];
         2'd2:    cur_nib = sh_value_q[11:8];
         default: cur_nib = sh_value_q[15:12];
      endcase
      digit_dark = sh_blank_q[idx_q] | lz_dark[idx_q];
      an_d       = C_AN_OFF;
      seg_d      = C_SEG_OFF;
      dp_d       = 1'b1;
      if (!in_guard && !digit_dark) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = hex_to_seg(cur_nib);
         dp_d  = ~sh_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         idx_q      <= 2'd0;
         sh_value_q <= 16'h0000;
         sh_dp_q    <= 4'b0000;
         sh_blank_q <= 4'b0000;
         seg_q      <= C_SEG_OFF;
         dp_q       <= 1'b1;
         an_q       <= C_AN_OFF;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         sh_value_q <= sh_value_d;
         sh_dp_q    <= sh_dp_d;
         sh_blank_q <= sh_blank_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
      end
   end

   assign seg = seg_q;
   assign dp  = dp_q;
   assign an  = an_q;

endmodule
`default_nettype wire
